// File: rtl/z3_tenure_limiter.sv
// z3_tenure_limiter
//
// Fairness controller for Zorro III DMA bus tenures. It sits beside the bus
// arbiter on clk100 and counts the full Z3 cycles (FCS assertions) performed
// by the granted master. Once the programmable quota is used up and someone
// else is waiting, it asks the arbiter to end the tenure. After every tenure
// it holds a CPU window of CPU_GAP cpuclk_rising events before another Z3
// tenure may begin.
//
// Ports:
//   clk100         system clock
//   reset_n        asynchronous active-low reset
//   cpuclk_rising  one-clk100 pulse per CPU clock rising edge
//   fcs_n_in       raw Zorro FCS (asynchronous, active-low)
//   bm_z3          high while the arbiter's bus-master state is Z3
//   z3_grant       arbiter's current Z3 grant (one-hot or zero)
//   z3_requests    registered Z3 requests from the arbiter
//   sdmac_req      synchronized SDMAC request
//   quota_wr       load the quota register this cycle
//   quota_wdata    new quota value (0 = unlimited)
//   preempt_req    arbiter must negate EBG and end the tenure
//   cpu_window     arbiter must not start a new Z3 tenure while high
//   tenure_count   Z3 cycles counted in the current/last tenure (saturating)
//   owner          grant captured at tenure start
//   grant_error    sticky: non-one-hot grant, or tenure start inside window

module z3_tenure_limiter #(
  parameter int          NUM_SLOTS     = 5,
  parameter int          QUOTA_W       = 8,
  parameter int unsigned DEFAULT_QUOTA = 64,
  parameter int          CPU_GAP       = 4
) (
  input  logic                 clk100,
  input  logic                 reset_n,
  input  logic                 cpuclk_rising,
  input  logic                 fcs_n_in,
  input  logic                 bm_z3,
  input  logic [NUM_SLOTS-1:0] z3_grant,
  input  logic [NUM_SLOTS-1:0] z3_requests,
  input  logic                 sdmac_req,
  input  logic                 quota_wr,
  input  logic [QUOTA_W-1:0]   quota_wdata,
  output logic                 preempt_req,
  output logic                 cpu_window,
  output logic [QUOTA_W-1:0]   tenure_count,
  output logic [NUM_SLOTS-1:0] owner,
  output logic                 grant_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TENURE,
    ST_PREEMPT,
    ST_GAP
  } state_t;

  localparam logic [QUOTA_W-1:0]   QUOTA_RST = QUOTA_W'(DEFAULT_QUOTA);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = NUM_SLOTS'(1);
  localparam logic [3:0]           GAP_LAST  = 4'(CPU_GAP - 1);

  state_t               state;
  state_t               state_next;
  logic [2:0]           fcs_sync;
  logic [QUOTA_W-1:0]   quota;
  logic [QUOTA_W-1:0]   count_next;
  logic [QUOTA_W-1:0]   count_inc;
  logic [NUM_SLOTS-1:0] owner_next;
  logic [3:0]           gap_cnt;
  logic [3:0]           gap_next;
  logic                 error_next;
  logic                 start_tenure;
  logic                 fcs_fall;
  logic                 fcs_negated;
  logic                 competitor;
  logic                 grant_onehot;

  // fcs_sync[1] is the newest metastability-safe sample, fcs_sync[2] the one
  // before it; a 1 -> 0 step between them marks the start of a Z3 cycle.
  assign fcs_fall    = fcs_sync[2] & ~fcs_sync[1];
  assign fcs_negated = fcs_sync[1];

  // The owner's own request does not count as competition.
  assign competitor   = (|(z3_requests & ~owner)) | sdmac_req;
  assign grant_onehot = (z3_grant != '0) && ((z3_grant & (z3_grant - SLOT_ONE)) == '0);
  assign count_inc    = (tenure_count == '1) ? tenure_count : tenure_count + QUOTA_W'(1);

  // Next-state logic. Leaving a tenure on bm_z3 low wins over preemption,
  // and a counted FCS edge in that same cycle is still added to the count.
  always_comb begin
    state_next   = state;
    count_next   = tenure_count;
    owner_next   = owner;
    gap_next     = gap_cnt;
    error_next   = grant_error;
    start_tenure = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bm_z3) begin
          start_tenure = 1'b1;
        end
      end

      ST_TENURE: begin
        if (fcs_fall) begin
          count_next = count_inc;
        end
        if (!bm_z3) begin
          state_next = ST_GAP;
          gap_next   = '0;
        end else if ((quota != '0) && (tenure_count >= quota) && competitor && fcs_negated) begin
          state_next = ST_PREEMPT;
        end
      end

      ST_PREEMPT: begin
        if (fcs_fall) begin
          count_next = count_inc;
        end
        if (!bm_z3) begin
          state_next = ST_GAP;
          gap_next   = '0;
        end
      end

      ST_GAP: begin
        if (bm_z3) begin
          error_next   = 1'b1;
          start_tenure = 1'b1;
        end else if (cpuclk_rising) begin
          if (gap_cnt == GAP_LAST) begin
            state_next = ST_IDLE;
          end else begin
            gap_next = gap_cnt + 4'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (start_tenure) begin
      state_next = ST_TENURE;
      owner_next = z3_grant;
      count_next = '0;
      if (!grant_onehot) begin
        error_next = 1'b1;
      end
    end
  end

  // State, counters and registered outputs. preempt_req and cpu_window are
  // decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      fcs_sync     <= '1;
      quota        <= QUOTA_RST;
      tenure_count <= '0;
      owner        <= '0;
      gap_cnt      <= '0;
      grant_error  <= 1'b0;
      preempt_req  <= 1'b0;
      cpu_window   <= 1'b0;
    end else begin
      state        <= state_next;
      fcs_sync     <= {fcs_sync[1:0], fcs_n_in};
      tenure_count <= count_next;
      owner        <= owner_next;
      gap_cnt      <= gap_next;
      grant_error  <= error_next;
      preempt_req  <= (state_next == ST_PREEMPT);
      cpu_window   <= (state_next == ST_GAP);
      if (quota_wr) begin
        quota <= quota_wdata;
      end
    end
  end

endmodule

// File: tb/tb_z3_tenure_limiter.sv
// tb_z3_tenure_limiter
//
// Scoreboard bench for z3_tenure_limiter. Each tenure's expected outcome
// (whether it is preempted, the count at preemption, the final count and
// owner) is derived from quota/competition/pulse-count rules and queued
// before the tenure is driven. A monitor pops entries whenever the DUT
// raises preempt_req or ends a CPU window, and also counts the CPU pulses
// seen inside each window.

`timescale 1ns/1ps

module tb_z3_tenure_limiter;

  localparam int NUM_SLOTS = 5;
  localparam int QUOTA_W   = 8;
  localparam int CPU_GAP   = 4;
  localparam int COUNT_MAX = (1 << QUOTA_W) - 1;

  logic                 clk100 = 1'b0;
  logic                 reset_n;
  logic                 cpuclk_rising;
  logic                 fcs_n_in;
  logic                 bm_z3;
  logic [NUM_SLOTS-1:0] z3_grant;
  logic [NUM_SLOTS-1:0] z3_requests;
  logic                 sdmac_req;
  logic                 quota_wr;
  logic [QUOTA_W-1:0]   quota_wdata;
  logic                 preempt_req;
  logic                 cpu_window;
  logic [QUOTA_W-1:0]   tenure_count;
  logic [NUM_SLOTS-1:0] owner;
  logic                 grant_error;

  int n_checks    = 0;
  int n_fail      = 0;
  int model_quota = 64;
  bit monitor_en  = 1'b1;
  bit cpu_gen_en  = 1'b1;

  typedef enum int {EV_PREEMPT = 0, EV_END = 1} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       count;
    int       owner;
    int       preempted;
  } exp_t;
  exp_t exp_q[$];

  z3_tenure_limiter #(
    .NUM_SLOTS(NUM_SLOTS),
    .QUOTA_W(QUOTA_W),
    .DEFAULT_QUOTA(64),
    .CPU_GAP(CPU_GAP)
  ) dut (
    .clk100(clk100),
    .reset_n(reset_n),
    .cpuclk_rising(cpuclk_rising),
    .fcs_n_in(fcs_n_in),
    .bm_z3(bm_z3),
    .z3_grant(z3_grant),
    .z3_requests(z3_requests),
    .sdmac_req(sdmac_req),
    .quota_wr(quota_wr),
    .quota_wdata(quota_wdata),
    .preempt_req(preempt_req),
    .cpu_window(cpu_window),
    .tenure_count(tenure_count),
    .owner(owner),
    .grant_error(grant_error)
  );

  always #5 clk100 = ~clk100;

  // Random CPU clock pulses, driven on the falling edge like all stimulus.
  initial begin : cpu_pulse_gen
    cpuclk_rising = 1'b0;
    forever begin
      @(negedge clk100);
      cpuclk_rising = cpu_gen_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic writeQuota(input int q);
    @(negedge clk100);
    quota_wr    = 1'b1;
    quota_wdata = QUOTA_W'(q);
    @(negedge clk100);
    quota_wr    = 1'b0;
    model_quota = q;
  endtask

  task automatic startTenure(input logic [NUM_SLOTS-1:0] grant,
                             input logic [NUM_SLOTS-1:0] reqs,
                             input logic sd);
    @(negedge clk100);
    z3_grant    = grant;
    z3_requests = reqs;
    sdmac_req   = sd;
    bm_z3       = 1'b1;
    repeat (2) @(negedge clk100);
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic fcsPulse(input int low_cycles, input int high_cycles);
    fcs_n_in = 1'b0;
    repeat (low_cycles) @(negedge clk100);
    fcs_n_in = 1'b1;
    repeat (high_cycles) @(negedge clk100);
  endtask

  task automatic endTenure();
    repeat (6) @(negedge clk100);
    bm_z3 = 1'b0;
    for (int i = 0; i < 400 && cpu_window !== 1'b1; i++) @(negedge clk100);
    checkOutput("cpu_window_rise", int'(cpu_window), 1);
    for (int i = 0; i < 400 && cpu_window !== 1'b0; i++) @(negedge clk100);
    checkOutput("cpu_window_fall", int'(cpu_window), 0);
    z3_requests = '0;
    z3_grant    = '0;
    sdmac_req   = 1'b0;
    @(negedge clk100);
  endtask

  // One complete tenure. q < 0 keeps the current quota. The expected outcome
  // follows from the quota rules: preemption needs a nonzero quota, at least
  // quota cycles and a competitor; with an early competitor it fires right
  // after the quota-th cycle, with a late SDMAC request after all n cycles.
  task automatic applyStimulus(input int q, input int slot, input logic [NUM_SLOTS-1:0] reqs,
                               input bit sd_early, input bit sd_late, input int n);
    logic [NUM_SLOTS-1:0] grant;
    bit   comp;
    bit   will_pre;
    int   sat;
    exp_t e;
    if (q >= 0) writeQuota(q);
    grant = NUM_SLOTS'(1 << slot);
    comp  = sd_early;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (i != slot && reqs[i]) comp = 1'b1;
    end
    sat      = (n > COUNT_MAX) ? COUNT_MAX : n;
    will_pre = (model_quota != 0) && (n >= model_quota) && (comp || sd_late);
    if (will_pre) begin
      e.kind      = EV_PREEMPT;
      e.count     = comp ? model_quota : sat;
      e.owner     = int'(grant);
      e.preempted = 1;
      exp_q.push_back(e);
    end
    e.kind      = EV_END;
    e.count     = sat;
    e.owner     = int'(grant);
    e.preempted = will_pre ? 1 : 0;
    exp_q.push_back(e);

    startTenure(grant, reqs, sd_early);
    for (int p = 0; p < n; p++) fcsPulse(2, 6);
    if (sd_late) begin
      repeat (3) @(negedge clk100);
      sdmac_req = 1'b1;
      repeat (4) @(negedge clk100);
    end
    endTenure();
  endtask

  // Monitor: reacts to preempt_req rising and cpu_window falling.
  initial begin : monitor
    bit   prev_pre;
    bit   prev_win;
    bit   pre_seen;
    int   gap_pulses;
    exp_t e;
    prev_pre   = 1'b0;
    prev_win   = 1'b0;
    pre_seen   = 1'b0;
    gap_pulses = 0;
    forever begin
      @(posedge clk100);
      #1;
      if (reset_n !== 1'b1) begin
        prev_pre   = 1'b0;
        prev_win   = 1'b0;
        pre_seen   = 1'b0;
        gap_pulses = 0;
      end else begin
        if (prev_win && cpuclk_rising) gap_pulses++;

        if (preempt_req && !prev_pre) begin
          pre_seen = 1'b1;
          if (monitor_en) begin
            if (exp_q.size() == 0) begin
              checkOutput("preempt_unexpected", int'(preempt_req), 0);
            end else begin
              e = exp_q.pop_front();
              if (e.kind != EV_PREEMPT) begin
                checkOutput("preempt_unexpected", int'(preempt_req), 0);
                exp_q.push_front(e);
              end else begin
                checkOutput("preempt_count", int'(tenure_count), e.count);
                checkOutput("preempt_owner", int'(owner), e.owner);
              end
            end
          end
        end

        if (cpu_window && !prev_win) begin
          gap_pulses = 0;
          if (monitor_en) checkOutput("preempt_clear_at_gap", int'(preempt_req), 0);
        end

        if (!cpu_window && prev_win) begin
          if (monitor_en) begin
            while (exp_q.size() != 0 && exp_q[0].kind == EV_PREEMPT) begin
              e = exp_q.pop_front();
              checkOutput("missing_preempt", int'(pre_seen), 1);
            end
            if (exp_q.size() == 0) begin
              checkOutput("window_end_unexpected", int'(cpu_window), 1);
            end else begin
              e = exp_q.pop_front();
              checkOutput("end_count", int'(tenure_count), e.count);
              checkOutput("end_owner", int'(owner), e.owner);
              checkOutput("end_preempted", int'(pre_seen), e.preempted);
              checkOutput("gap_pulses", gap_pulses, CPU_GAP);
            end
          end
          pre_seen = 1'b0;
        end

        prev_pre = preempt_req;
        prev_win = cpu_window;
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    reset_n     = 1'b0;
    fcs_n_in    = 1'b1;
    bm_z3       = 1'b0;
    z3_grant    = '0;
    z3_requests = '0;
    sdmac_req   = 1'b0;
    quota_wr    = 1'b0;
    quota_wdata = '0;

    repeat (3) @(negedge clk100);
    checkOutput("reset_preempt_req", int'(preempt_req), 0);
    checkOutput("reset_cpu_window", int'(cpu_window), 0);
    checkOutput("reset_tenure_count", int'(tenure_count), 0);
    checkOutput("reset_owner", int'(owner), 0);
    checkOutput("reset_grant_error", int'(grant_error), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk100);

    $display("[TB] quota 3, slot 3 competing, 3 cycles");
    applyStimulus(3, 1, 5'b01000, 1'b0, 1'b0, 3);

    $display("[TB] quota 3, no competitor, 10 cycles, late SDMAC request");
    applyStimulus(3, 0, 5'b00001, 1'b0, 1'b1, 10);

    $display("[TB] unlimited quota, 300 cycles, saturation");
    applyStimulus(0, 2, 5'b10000, 1'b1, 1'b0, 300);

    $display("[TB] quota reached while FCS held low");
    writeQuota(2);
    e.kind = EV_PREEMPT; e.count = 2; e.owner = 1; e.preempted = 1;
    exp_q.push_back(e);
    e.kind = EV_END; e.count = 2; e.owner = 1; e.preempted = 1;
    exp_q.push_back(e);
    startTenure(5'b00001, 5'b00100, 1'b0);
    fcsPulse(2, 6);
    fcs_n_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk100);
      checkOutput("preempt_held_fcs_low", int'(preempt_req), 0);
    end
    checkOutput("count_while_fcs_low", int'(tenure_count), 2);
    fcs_n_in = 1'b1;
    @(posedge clk100); #1;
    checkOutput("preempt_sync_stage1", int'(preempt_req), 0);
    @(posedge clk100); #1;
    checkOutput("preempt_sync_stage2", int'(preempt_req), 0);
    @(posedge clk100); #1;
    checkOutput("preempt_after_negation", int'(preempt_req), 1);
    endTenure();

    $display("[TB] random tenures");
    for (int t = 0; t < 25; t++) begin
      int q;
      q = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 8));
      applyStimulus(q, int'($urandom_range(0, NUM_SLOTS - 1)),
                    NUM_SLOTS'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 12)));
    end

    $display("[TB] non-one-hot grant");
    monitor_en = 1'b0;
    startTenure(5'b00110, 5'b00000, 1'b0);
    checkOutput("multi_grant_error", int'(grant_error), 1);
    checkOutput("multi_grant_owner", int'(owner), 6);
    endTenure();
    reset_n = 1'b0;
    #1;
    checkOutput("grant_error_reset", int'(grant_error), 0);
    repeat (2) @(negedge clk100);
    reset_n = 1'b1;
    model_quota = 64;

    $display("[TB] tenure start during CPU window");
    cpu_gen_en = 1'b0;
    startTenure(5'b00001, 5'b00000, 1'b0);
    bm_z3 = 1'b0;
    repeat (3) @(negedge clk100);
    checkOutput("gap_window_open", int'(cpu_window), 1);
    checkOutput("gap_no_error_yet", int'(grant_error), 0);
    z3_grant = 5'b00100;
    bm_z3    = 1'b1;
    @(posedge clk100); #1;
    checkOutput("gap_start_error", int'(grant_error), 1);
    checkOutput("gap_start_window", int'(cpu_window), 0);
    checkOutput("gap_start_owner", int'(owner), 4);
    checkOutput("gap_start_count", int'(tenure_count), 0);
    @(negedge clk100);
    fcsPulse(2, 6);
    checkOutput("gap_start_counting", int'(tenure_count), 1);
    cpu_gen_en = 1'b1;
    endTenure();

    $display("[TB] reset during preemption");
    reset_n = 1'b0;
    repeat (2) @(negedge clk100);
    reset_n    = 1'b1;
    monitor_en = 1'b1;
    @(negedge clk100);
    writeQuota(7);
    e.kind = EV_PREEMPT; e.count = 7; e.owner = 2; e.preempted = 1;
    exp_q.push_back(e);
    startTenure(5'b00010, 5'b01000, 1'b0);
    for (int p = 0; p < 7; p++) fcsPulse(2, 6);
    checkOutput("preempt_before_reset", int'(preempt_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_preempt_req", int'(preempt_req), 0);
    checkOutput("async_reset_cpu_window", int'(cpu_window), 0);
    checkOutput("async_reset_tenure_count", int'(tenure_count), 0);
    checkOutput("async_reset_owner", int'(owner), 0);
    bm_z3       = 1'b0;
    z3_grant    = '0;
    z3_requests = '0;
    repeat (3) @(negedge clk100);
    reset_n     = 1'b1;
    model_quota = 64;
    applyStimulus(-1, 1, 5'b01000, 1'b0, 1'b0, 7);

    repeat (4) @(negedge clk100);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
